// File: rtl/iomem_timer_pkg.sv
// Shared constants and helpers for the iomem timer peripheral.
package iomem_timer_pkg;

  localparam logic [31:0] DEFAULT_ADDR_BASE = 32'h0300_0000;

  // Word offsets, i.e. iomem_addr[7:2]
  localparam logic [5:0] REG_CTRL   = 6'h00;
  localparam logic [5:0] REG_PRESC  = 6'h01;
  localparam logic [5:0] REG_COUNT  = 6'h02;
  localparam logic [5:0] REG_RELOAD = 6'h03;
  localparam logic [5:0] REG_STATUS = 6'h04;

  localparam int unsigned CTRL_EN     = 0;
  localparam int unsigned CTRL_AUTO   = 1;
  localparam int unsigned CTRL_IRQ_EN = 2;

  function automatic logic [31:0] apply_wstrb(input logic [31:0] old_val,
                                              input logic [31:0] wdata,
                                              input logic [3:0]  wstrb);
    logic [31:0] res;
    res = old_val;
    for (int b = 0; b < 4; b++) begin
      if (wstrb[b]) res[8*b +: 8] = wdata[8*b +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/iomem_timer_if.sv
// picosoc iomem bus as seen by a single peripheral.
interface iomem_timer_if;
  logic        valid;
  logic        ready;
  logic [3:0]  wstrb;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [31:0] rdata;

  modport master (output valid, wstrb, addr, wdata, input ready, rdata);
  modport slave  (input valid, wstrb, addr, wdata, output ready, rdata);
endinterface

// File: rtl/iomem_timer_presc.sv
// Prescaler: counts 0..presc while enabled, ticking on the terminal value.
module iomem_timer_presc #(
  parameter int unsigned PRESC_W = 16
) (
  input  logic               clk,
  input  logic               resetn,
  input  logic               en,
  input  logic               clr,
  input  logic [PRESC_W-1:0] presc,
  output logic               tick
);

  logic [PRESC_W-1:0] pcnt_q, pcnt_d;

  assign tick = en && (pcnt_q == presc);

  always_comb begin
    pcnt_d = pcnt_q;
    if (clr || tick) begin
      pcnt_d = '0;
    end else if (en) begin
      pcnt_d = pcnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) pcnt_q <= '0;
    else         pcnt_q <= pcnt_d;
  end

endmodule

// File: rtl/iomem_timer.sv
// Down-counting timer/compare peripheral on the picosoc iomem bus with a
// one-cycle ready handshake and a one-cycle terminal-count interrupt pulse.
module iomem_timer
  import iomem_timer_pkg::*;
#(
  parameter logic [31:0] ADDR_BASE = DEFAULT_ADDR_BASE,
  parameter int unsigned PRESC_W   = 16
) (
  input  logic          clk,
  input  logic          resetn,
  iomem_timer_if.slave  bus,
  output logic          irq
);

  logic [2:0]         ctrl_q, ctrl_d;
  logic [PRESC_W-1:0] presc_q, presc_d;
  logic [31:0]        count_q, count_d;
  logic [31:0]        reload_q, reload_d;
  logic               match_q, match_d;
  logic               ready_q, irq_q;
  logic [31:0]        rdata_q, rdata_d, rd_val;

  logic       sel, we, tick, term, cpu_wins;
  logic       wr_ctrl, wr_presc, wr_count, wr_reload, wr_status;
  logic [5:0] off;
  logic [15:0] presc16, presc_wr;

  // !ready_q keeps a held valid from being acked twice
  assign sel = bus.valid && (bus.addr[31:8] == ADDR_BASE[31:8]) && !ready_q;
  assign off = bus.addr[7:2];
  assign we  = sel && (bus.wstrb != 4'b0000);

  assign wr_ctrl   = we && (off == REG_CTRL);
  assign wr_presc  = we && (off == REG_PRESC);
  assign wr_count  = we && (off == REG_COUNT);
  assign wr_reload = we && (off == REG_RELOAD);
  assign wr_status = we && (off == REG_STATUS);
  assign cpu_wins  = wr_ctrl || wr_count;

  assign term = tick && (count_q == '0);

  iomem_timer_presc #(
    .PRESC_W (PRESC_W)
  ) u_presc (
    .clk    (clk),
    .resetn (resetn),
    .en     (ctrl_q[CTRL_EN]),
    .clr    (wr_count),
    .presc  (presc_q),
    .tick   (tick)
  );

  always_comb begin
    rd_val = '0;
    case (off)
      REG_CTRL:   rd_val = {29'b0, ctrl_q};
      REG_PRESC:  rd_val = 32'(presc_q);
      REG_COUNT:  rd_val = count_q;
      REG_RELOAD: rd_val = reload_q;
      REG_STATUS: rd_val = {31'b0, match_q};
      default:    rd_val = '0;
    endcase
  end

  assign rdata_d  = (sel && (bus.wstrb == 4'b0000)) ? rd_val : '0;
  assign presc16  = 16'(presc_q);
  assign presc_wr = {bus.wstrb[1] ? bus.wdata[15:8] : presc16[15:8],
                     bus.wstrb[0] ? bus.wdata[7:0]  : presc16[7:0]};

  always_comb begin
    ctrl_d   = ctrl_q;
    presc_d  = presc_q;
    count_d  = count_q;
    reload_d = reload_q;
    match_d  = match_q;

    // A CPU write to CTRL or COUNT overrides every counter side effect of a tick
    if (tick && !cpu_wins) begin
      if (count_q != '0)          count_d = count_q - 32'd1;
      else if (ctrl_q[CTRL_AUTO]) count_d = reload_q;
      else                        ctrl_d[CTRL_EN] = 1'b0;
    end

    if (wr_ctrl && bus.wstrb[0]) ctrl_d = bus.wdata[2:0];
    if (wr_presc)  presc_d  = presc_wr[PRESC_W-1:0];
    if (wr_count)  count_d  = apply_wstrb(count_q, bus.wdata, bus.wstrb);
    if (wr_reload) reload_d = apply_wstrb(reload_q, bus.wdata, bus.wstrb);

    if (wr_status && bus.wstrb[0] && bus.wdata[0]) match_d = 1'b0;
    if (term) match_d = 1'b1;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      ctrl_q   <= '0;
      presc_q  <= '0;
      count_q  <= '0;
      reload_q <= '0;
      match_q  <= 1'b0;
      ready_q  <= 1'b0;
      rdata_q  <= '0;
      irq_q    <= 1'b0;
    end else begin
      ctrl_q   <= ctrl_d;
      presc_q  <= presc_d;
      count_q  <= count_d;
      reload_q <= reload_d;
      match_q  <= match_d;
      ready_q  <= sel;
      rdata_q  <= rdata_d;
      irq_q    <= term && ctrl_q[CTRL_IRQ_EN];
    end
  end

  assign bus.ready = ready_q;
  assign bus.rdata = rdata_q;
  assign irq       = irq_q;

endmodule

// File: doc/iomem_timer.md
Name: iomem_timer

Overview:
- 32-bit down-counting timer/compare peripheral on the picosoc iomem bus, directly downstream of the SoC's iomem port.
- Decodes its own address window and answers iomem transactions with a one-cycle ready handshake.
- Raises a one-cycle interrupt pulse, wired to irq_5 at SoC top level, on each terminal count.

Parameters:
- ADDR_BASE, 32'h0300_0000, window base; only bits [31:8] are compared (256-byte window).
- PRESC_W, 16, prescaler width in bits (1..16).

Ports:
- clk  in  1  system clock; all logic on rising edge.
- resetn  in  1  asynchronous, active-low reset.
- iomem_valid  in  1  bus request from SoC.
- iomem_ready  out  1  one-cycle acknowledge for a selected access.
- iomem_wstrb  in  4  byte write enables; 4'b0000 means read.
- iomem_addr  in  32  byte address.
- iomem_wdata  in  32  write data.
- iomem_rdata  out  32  read data, valid only while iomem_ready=1; 0 otherwise.
- irq  out  1  one-cycle interrupt pulse.

Behaviour:
- Reset (async, resetn=0): iomem_ready=0, iomem_rdata=0, irq=0, and all registers and internal counters = 0. Reset mid-operation aborts any pending access and clears the flag with no irq.
- Select: sel = iomem_valid && iomem_addr[31:8]==ADDR_BASE[31:8] && !iomem_ready.
- Handshake:
  - sel in cycle N gives iomem_ready=1 in cycle N+1, for exactly one cycle.
  - The write is committed at the same edge that raises ready.
  - Because of the !iomem_ready term, valid held high after ready cannot produce a second ack.
  - Unselected addresses never assert ready.
- Register map (offset = addr[7:2]; byte lanes per wstrb; unmapped offsets read 0 and ignore writes, but are still acked):
  - 0x00 CTRL: bit0 EN, bit1 AUTO (auto-reload), bit2 IRQ_EN; other bits read 0.
  - 0x04 PRESC [PRESC_W-1:0]: prescaler terminal value.
  - 0x08 COUNT: current count. A write loads it and also clears the prescaler counter.
  - 0x0C RELOAD: reload value.
  - 0x10 STATUS: bit0 MATCH flag, write-1-to-clear; reads return the flag.
- Prescaler: pcnt counts 0..PRESC while EN=1.
  - tick=1 when pcnt==PRESC, and pcnt wraps to 0 on the same edge.
  - PRESC=0 gives a tick every cycle.
  - EN=0 holds pcnt.
- Counter, on tick with EN=1:
  - If COUNT!=0: COUNT <= COUNT-1.
  - If COUNT==0 (terminal): MATCH<=1 and irq pulses for 1 cycle if IRQ_EN. Then, if AUTO: COUNT<=RELOAD. If not AUTO: COUNT stays 0 and EN<=0 (one-shot).
  - Terminal-to-irq latency: irq is high in the cycle after the terminal tick edge.
- Arithmetic: COUNT is unsigned 32-bit. RELOAD=0 with AUTO gives a terminal event every tick.
- Simultaneous events:
  - A CPU write to COUNT or CTRL in the same cycle as a tick: the CPU write wins; the tick's decrement, reload and EN clear are discarded, but MATCH/irq from that tick still fire.
  - A STATUS W1C coinciding with a new terminal event: set wins, and MATCH stays 1.
- Read data is sampled on the same edge that raises ready. A read of STATUS or COUNT returns the pre-update value of that edge.

Decomposition:
- Shared package iomem_timer_pkg holds:
  - register offset constants REG_CTRL/REG_PRESC/REG_COUNT/REG_RELOAD/REG_STATUS;
  - CTRL bit index constants;
  - the default ADDR_BASE.
- One sub-module, iomem_timer_presc: the prescaler counter (inputs en, presc, clr; output tick).
- Bus decode, register file and counter stay in the top block.

Test Plan:
- Reset then read all five offsets → each access acked exactly 1 cycle after valid, rdata=0; access to 0x0400_0000 → ready never asserts within 16 cycles.
- PRESC=0, RELOAD=3, COUNT=3, CTRL=0b111 → COUNT sequence 3,2,1,0,3…; irq 1-cycle pulse every 4 cycles; STATUS reads 1; writing 1 to STATUS clears it.
- PRESC=4, COUNT=2, CTRL=0b101 (one-shot) → irq once after 15 cycles (3 ticks × 5); EN reads 0 afterwards; COUNT holds 0 with no further irq.
- Byte write wstrb=4'b0010, wdata=32'h0000_AB00 to RELOAD=32'h1122_3344 → RELOAD reads 32'h1122_AB44.
- Write COUNT=100 in the same cycle as a tick with COUNT=5 → COUNT reads 100 and the prescaler restarts from 0; STATUS W1C in the same cycle as a terminal event → MATCH remains 1.
- Drop resetn asynchronously mid-count, including between valid and ready → outputs 0 immediately with no ready, irq or MATCH; after release, EN=0 and the counter is idle.
